// File: rtl/seq_counter_gen2_if.sv
// Control/status bundle for the parametrised up/down sequence counter.
// The master drives the controls and the slave (the counter) returns count, tc and wrap status.
interface seq_counter_gen2_if #(
    parameter int WIDTH  = 8,
    parameter int WRAP_W = 4
);
    logic              clr;
    logic              en;
    logic              up;
    logic              sat_mode;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  max_val;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              wrap;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output clr, en, up, sat_mode, load, load_val, max_val,
        input  count, tc, wrap, wrap_cnt
    );

    modport slave (
        input  clr, en, up, sat_mode, load, load_val, max_val,
        output count, tc, wrap, wrap_cnt
    );
endinterface

// File: rtl/seq_counter_gen2.sv
// Up/down sequence counter over 0..max_val with wrap or saturate at the bounds.
// It also has sync clear, parallel load, a terminal-count flag and a wrap-event counter.
module seq_counter_gen2 #(
    parameter int WIDTH     = 8,
    parameter int RESET_VAL = 0,
    parameter int WRAP_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    seq_counter_gen2_if.slave   bus
);
    localparam logic [WIDTH-1:0]  RESET_CNT = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0]  ONE_CNT   = WIDTH'(1);
    localparam logic [WRAP_W-1:0] ONE_WRAP  = WRAP_W'(1);

    logic [WIDTH-1:0]  count_q, count_d;
    logic              wrap_q, wrap_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic              wrap_event;
    logic              at_top;
    logic              at_bottom;

    // Up direction: a count already at or above max_val counts as being at the top bound.
    assign at_top    = (count_q >= bus.max_val);
    assign at_bottom = (count_q == '0);

    always_comb begin
        count_d    = count_q;
        wrap_cnt_d = wrap_cnt_q;
        wrap_event = 1'b0;
        if (bus.clr) begin
            count_d    = RESET_CNT;
            wrap_cnt_d = '0;
        end else if (bus.load) begin
            count_d = (bus.load_val > bus.max_val) ? bus.max_val : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (!at_top) begin
                    count_d = count_q + ONE_CNT;
                end else if (bus.sat_mode) begin
                    count_d = bus.max_val;
                end else begin
                    count_d    = '0;
                    wrap_event = 1'b1;
                end
            end else begin
                // Down direction: pull an out-of-range count back to max_val before decrementing.
                if (count_q > bus.max_val) begin
                    count_d = bus.max_val;
                end else if (!at_bottom) begin
                    count_d = count_q - ONE_CNT;
                end else if (!bus.sat_mode) begin
                    count_d    = bus.max_val;
                    wrap_event = 1'b1;
                end
            end
        end
        wrap_d = wrap_event;
        if (wrap_event) begin
            wrap_cnt_d = wrap_cnt_q + ONE_WRAP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= RESET_CNT;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.wrap_cnt = wrap_cnt_q;
    assign bus.tc       = bus.en & ~bus.clr & ~bus.load & (bus.up ? at_top : at_bottom);
endmodule

// File: tb/tb_seq_counter_gen2.sv
// Self-checking bench for seq_counter_gen2: table-driven vectors, hand corner sequences,
// then randomized stimulus against an arithmetic reference model.
module tb_seq_counter_gen2;
   localparam int WIDTH  = 8;
   localparam int WRAP_W = 4;

   typedef struct {
      logic clr;
      logic load;
      logic en;
      logic up;
      logic sat;
      int   lv;
      int   mv;
      logic exp_tc;
      int   exp_cnt;
      logic exp_wrap;
      int   exp_wc;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t vecs[$];

   int   m_cnt;
   int   m_wrap;
   int   m_wc;

   seq_counter_gen2_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

   seq_counter_gen2 #(.WIDTH(WIDTH), .RESET_VAL(0), .WRAP_W(WRAP_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(logic c, logic l, logic e, logic u, logic s, int lv, int mv,
                               logic t, int cnt, logic w, int wc);
      vec_t v;
      v.clr = c; v.load = l; v.en = e; v.up = u; v.sat = s; v.lv = lv; v.mv = mv;
      v.exp_tc = t; v.exp_cnt = cnt; v.exp_wrap = w; v.exp_wc = wc;
      return v;
   endfunction

   // Every comparison in the bench goes through here so the counters stay consistent.
   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d want=%0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic c, input logic l, input logic e, input logic u,
                                input logic s, input int lv, input int mv);
      bus.clr      = c;
      bus.load     = l;
      bus.en       = e;
      bus.up       = u;
      bus.sat_mode = s;
      bus.load_val = WIDTH'(lv);
      bus.max_val  = WIDTH'(mv);
   endtask

   // Drive one vector shortly after an edge, check tc before the next edge, then check the registers after it.
   task automatic runVec(input string name, input vec_t v);
      applyStimulus(v.clr, v.load, v.en, v.up, v.sat, v.lv, v.mv);
      #2;
      checkOutput({name, ".tc"}, int'(bus.tc), int'(v.exp_tc));
      @(posedge clk);
      #1;
      checkOutput({name, ".count"}, int'(bus.count), v.exp_cnt);
      checkOutput({name, ".wrap"}, int'(bus.wrap), int'(v.exp_wrap));
      checkOutput({name, ".wrap_cnt"}, int'(bus.wrap_cnt), v.exp_wc);
   endtask

   // Reference model: the count lives on the ring 0..mv and steps by modular arithmetic.
   function automatic int modelTc(int c, logic cl, logic ld, logic e, logic u, int mv);
      if (!e || cl || ld) return 0;
      if (u) return (c >= mv) ? 1 : 0;
      return (c == 0) ? 1 : 0;
   endfunction

   task automatic modelStep(input logic cl, input logic ld, input logic e, input logic u,
                            input logic s, input int lv, input int mv);
      int ev;
      ev = 0;
      if (cl) begin
         m_cnt = 0;
         m_wc  = 0;
      end else if (ld) begin
         m_cnt = (lv < mv) ? lv : mv;
      end else if (e) begin
         if (m_cnt > mv) begin
            if (!u) m_cnt = mv;
            else if (s) m_cnt = mv;
            else begin m_cnt = 0; ev = 1; end
         end else if (u && m_cnt == mv && s) begin
            m_cnt = mv;
         end else if (!u && m_cnt == 0 && s) begin
            m_cnt = 0;
         end else begin
            ev    = u ? int'(m_cnt == mv) : int'(m_cnt == 0);
            m_cnt = u ? (m_cnt + 1) % (mv + 1) : (m_cnt + mv) % (mv + 1);
         end
      end
      m_wrap = ev;
      m_wc   = (m_wc + ev) % (1 << WRAP_W);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      // Full wrap at max_val=7, then clear.
      for (int i = 0; i < 7; i++) vecs.push_back(mk(0,0,1,1,0,0,7, 0,i+1,0,0));
      vecs.push_back(mk(0,0,1,1,0,0,7, 1,0,1,1));
      vecs.push_back(mk(0,0,1,1,0,0,7, 0,1,0,1));
      vecs.push_back(mk(1,0,1,1,0,0,7, 0,0,0,0));
      // Saturating up at max_val=9.
      vecs.push_back(mk(0,1,1,1,1,7,9, 0,7,0,0));
      vecs.push_back(mk(0,0,1,1,1,0,9, 0,8,0,0));
      vecs.push_back(mk(0,0,1,1,1,0,9, 0,9,0,0));
      vecs.push_back(mk(0,0,1,1,1,0,9, 1,9,0,0));
      vecs.push_back(mk(0,0,1,1,1,0,9, 1,9,0,0));
      // Down with wrap at max_val=5 from a load of 2.
      vecs.push_back(mk(0,1,1,0,0,2,5, 0,2,0,0));
      vecs.push_back(mk(0,0,1,0,0,0,5, 0,1,0,0));
      vecs.push_back(mk(0,0,1,0,0,0,5, 0,0,0,0));
      vecs.push_back(mk(0,0,1,0,0,0,5, 1,5,1,1));
      vecs.push_back(mk(0,0,1,0,0,0,5, 0,4,0,1));
      // max_val=0: every enabled wrap-mode cycle is an event.
      vecs.push_back(mk(0,0,1,1,0,0,0, 1,0,1,2));
      vecs.push_back(mk(0,0,1,1,0,0,0, 1,0,1,3));
      vecs.push_back(mk(0,0,1,0,0,0,0, 1,0,1,4));
      vecs.push_back(mk(0,0,1,0,1,0,0, 1,0,0,4));
      vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,4));
      // Hold when disabled.
      vecs.push_back(mk(0,1,1,1,0,3,9, 0,3,0,4));
      vecs.push_back(mk(0,0,0,1,0,0,9, 0,3,0,4));

      #12;
      checkOutput("reset.count", int'(bus.count), 0);
      checkOutput("reset.wrap", int'(bus.wrap), 0);
      checkOutput("reset.wrap_cnt", int'(bus.wrap_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) runVec($sformatf("vec%0d", i), vecs[i]);

      // Load clamps to max_val; clear beats load in the same cycle.
      runVec("ldclamp", mk(0,1,1,1,0,200,50, 0,50,0,4));
      runVec("clrwins", mk(1,1,1,1,0,200,50, 0,0,0,0));

      // Lowering max_val below the current count.
      runVec("lower.ld1", mk(0,1,0,1,0,30,200, 0,30,0,0));
      runVec("lower.up", mk(0,0,1,1,0,0,10, 1,0,1,1));
      runVec("lower.ld2", mk(0,1,0,1,0,30,200, 0,30,0,1));
      runVec("lower.dn", mk(0,0,1,0,0,0,10, 0,10,0,1));

      // Seventeen wraps roll the 4-bit event counter over to 1.
      runVec("roll.clr", mk(1,0,0,1,0,0,0, 0,0,0,0));
      for (int k = 0; k < 17; k++)
         runVec($sformatf("roll%0d", k), mk(0,0,1,1,0,0,0, 1,0,1,(k + 1) % 16));
      runVec("roll.ld", mk(0,1,0,1,0,30,200, 0,30,0,1));
      runVec("roll.up", mk(0,0,1,1,0,0,200, 0,31,0,1));

      // Asynchronous reset between edges takes effect without a clock.
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async.count", int'(bus.count), 0);
      checkOutput("async.wrap", int'(bus.wrap), 0);
      checkOutput("async.wrap_cnt", int'(bus.wrap_cnt), 0);
      applyStimulus(0, 0, 0, 1, 0, 0, 10);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      m_cnt  = 0;
      m_wrap = 0;
      m_wc   = 0;
      for (int n = 0; n < 400; n++) begin
         logic cl, ld, e, u, s;
         int lv, mv;
         cl = ($urandom % 25) == 0;
         ld = ($urandom % 10) == 0;
         e  = ($urandom % 5) != 0;
         u  = $urandom % 2;
         s  = ($urandom % 3) == 0;
         lv = $urandom % 256;
         mv = (($urandom % 6) == 0) ? int'($urandom % 256) : int'($urandom % 8);
         applyStimulus(cl, ld, e, u, s, lv, mv);
         #2;
         checkOutput($sformatf("rnd%0d.tc", n), int'(bus.tc), modelTc(m_cnt, cl, ld, e, u, mv));
         @(posedge clk);
         #1;
         modelStep(cl, ld, e, u, s, lv, mv);
         checkOutput($sformatf("rnd%0d.count", n), int'(bus.count), m_cnt);
         checkOutput($sformatf("rnd%0d.wrap", n), int'(bus.wrap), m_wrap);
         checkOutput($sformatf("rnd%0d.wrap_cnt", n), int'(bus.wrap_cnt), m_wc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
